// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time controller for a toggle-type divide-by-N clock divider
//
// Purpose:
//   Owns the half-period counter and the divided output. Division starts and
//   stops cleanly: a stop request always lets the current high half and the
//   following low half run to full length. A new divisor arrives over a
//   valid/ready port and is applied only at a period boundary (falling edge of
//   div_out, or while idle), so div_out never shows a runt pulse.
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      asynchronous, active-low reset
//   en         in   1      level request: 1 = run divider, 0 = stop after full period
//   cfg_valid  in   1      new divisor offered
//   cfg_n      in   CNT_W  offered divisor (half-period length in clk cycles)
//   cfg_ready  out  1      controller can accept a divisor (= !busy)
//   cfg_err    out  1      1-cycle pulse: accepted cfg_n was 0, discarded
//   div_out    out  1      divided output, period 2*cur_n, 50% duty
//   running    out  1      1 when not idle
//   busy       out  1      a divisor is pending, not yet applied

module clk_div_ctrl #(
  parameter int          CNT_W     = 16,
  parameter int unsigned N_DEFAULT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_n,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             running,
  output logic             busy
);

  localparam logic [CNT_W-1:0] N_RST   = CNT_W'(N_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_n;
  logic [CNT_W-1:0] pend_n;
  logic             pending;

  logic term;          // last cycle of the current half period
  logic accept;        // handshake completes this cycle
  logic accept_ok;     // handshake with a usable (non-zero) divisor
  logic to_idle;       // STOP finishing its low half with no new run request
  logic apply_now;     // pending divisor becomes the current divisor
  logic direct_apply;  // divisor accepted while idle together with en rising

  assign term      = (state != IDLE) && (cnt == cur_n);
  assign accept    = cfg_valid && !pending;
  assign accept_ok = accept && (cfg_n != '0);
  assign to_idle   = (state == STOP) && term && !div_out && !en;

  // A pending divisor is applied while idle, or on the terminal cycle that
  // ends a high half (the falling edge), so a whole period always uses one
  // divisor. Leaving STOP for IDLE is also a period boundary.
  assign apply_now = pending && ((state == IDLE) || (term && (div_out || to_idle)));

  // Accept and en rise in the same idle cycle: the new divisor must already be
  // in force on the first RUN cycle, so it bypasses the pending register.
  assign direct_apply = accept_ok && (state == IDLE) && en;

  assign busy      = pending;
  assign cfg_ready = !pending;
  assign running   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= CNT_ONE;
      cur_n   <= N_RST;
      pend_n  <= N_RST;
      pending <= 1'b0;
      div_out <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      // Zero divisor is consumed by the handshake but never stored.
      cfg_err <= accept && (cfg_n == '0);

      // Accept and apply are mutually exclusive: accept needs pending=0,
      // apply needs pending=1.
      if (accept_ok) begin
        if (direct_apply) begin
          cur_n <= cfg_n;
        end else begin
          pend_n  <= cfg_n;
          pending <= 1'b1;
        end
      end

      if (apply_now) begin
        cur_n   <= pend_n;
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          div_out <= 1'b0;
          cnt     <= CNT_ONE;
          if (en) begin
            state <= RUN;
          end
        end

        RUN, STOP: begin
          // Counting never pauses in STOP; only the final low-half terminal
          // cycle suppresses the toggle and drops back to IDLE.
          if (term) begin
            cnt <= CNT_ONE;
            if (!to_idle) begin
              div_out <= ~div_out;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end

          // Re-raising en in STOP resumes RUN with no phase change.
          if (en) begin
            state <= RUN;
          end else if (to_idle) begin
            state <= IDLE;
          end else begin
            state <= STOP;
          end
        end

        default: begin
          state   <= IDLE;
          div_out <= 1'b0;
          cnt     <= CNT_ONE;
        end
      endcase
    end
  end

endmodule
